scancode_decoder: RTL and testbench
===================================

# scancode_decoder

Parametrised successor to the AT-to-lispm scancode converter. Accepts raw PS/2 set-2 bytes and decodes E0, F0 and E1 (Pause) prefixes. Tracks modifier state, optionally suppresses typematic repeats, and queues 16-bit lispm keycodes in an output FIFO with a valid/ready handshake. It sits between the PS/2 byte receiver and the keyboard register interface of the lispm I/O bus.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of 2, ≥2.
- SUPPRESS_REPEAT, 1: when 1, drop repeated make codes with no intervening break.
- PAUSE_CODE, 8'h7f: lispm code emitted for the Pause sequence.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- strobe_in  in  1  one-cycle pulse; code_in valid.
- code_in  in  8  raw scancode byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head entry this cycle.
- keycode  out  16  FIFO head; {3'b0, mods[3:0], up, code[7:0]}.
- overflow  out  1  sticky; a keycode was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow (push-drop in the same cycle wins).
- mods  out  4  live modifier state {caps_lock, meta, ctrl, shift}.

## Operation
- FSM states: S_IDLE, S_E0, S_F0, S_E0F0, S_E1, S_LOOKUP, S_PUSH.
- IDLE + strobe: E0→S_E0; F0→S_F0; E1→S_E1 (skip=7); any other byte→S_LOOKUP (up=0).
- S_E0 + strobe: F0→S_E0F0; other→S_LOOKUP (up=0, ext=1).
- S_F0 + strobe→S_LOOKUP (up=1). S_E0F0 + strobe→S_LOOKUP (up=1, ext=1).
- S_E1: each strobe decrements skip. After the 7th byte→S_LOOKUP with forced code PAUSE_CODE, up=0, ROM bypassed.
- S_LOOKUP→S_PUSH unconditionally. S_PUSH→S_IDLE unconditionally.
- Every strobe stores the byte in sc. The ROM is addressed by {ext, sc} (9 bits) and is combinational.
- strobe_in during S_LOOKUP or S_PUSH is ignored. The receiver guarantees ≥3 clk between bytes.
- S_LOOKUP updates modifiers from {ext, sc}:
  - 0_12/0_59 → shift.
  - 0_14/1_14 → ctrl.
  - 0_11/1_11 → meta. Set on make, clear on break; left and right sides are OR-ed via 2 bits each internally.
  - 0_58 make → toggles caps_lock.
- Repeat suppression: last_down (9 bits) records {ext, sc} of the last make.
  - A make equal to last_down is discarded: S_PUSH does not write.
  - A break equal to last_down clears last_down to 9'h1ff.
- Keycode mods field is the modifier state after the update, so a shift make carries shift=1.
- FIFO: rd/wr pointers are log2(DEPTH)+1 bits wide.
  - Full = MSBs differ and LSBs equal.
  - Empty = pointers equal.
- Push while full: entry dropped, overflow←1, pointers unchanged.
- Push and pop in the same cycle while full: the pop frees a slot and the push is accepted.
- Pop while empty: impossible, since out_valid=0.

## Timing
- Reset values: state S_IDLE, FIFO empty, out_valid 0, keycode 16'h0000, overflow 0, mods 4'h0, last_down 9'h1ff, prefix flags 0.
- Reset mid-sequence discards any partial prefix and the FIFO contents immediately, without waiting for a clock.
- Latency: final byte sampled at edge k → S_LOOKUP in cycle k+1 → written at edge k+2 → out_valid=1 in cycle k+2 when the FIFO was empty.
- keycode is the registered head entry; it is stable while out_valid=1 and out_ready=0.
- Pop occurs at the edge where out_valid and out_ready are both 1. The next entry appears the following cycle.
- overflow is set at the dropping edge and held until an ovf_clr edge with no concurrent drop.

## Structure
- Shared package scancode_pkg holds:
  - State encodings.
  - Modifier scancode constants (12, 59, 14, 11, 58).
  - Prefix bytes E0/F0/E1.
  - Keycode field offsets (UP_BIT=8, MODS_LSB=9).
- Sub-module keycode_fifo (DEPTH, 16-bit) holds the pointers, storage, full/empty and the overflow flag.
- Existing scancode_rom is instantiated unchanged.

## Test plan
- Bytes 1C, then F0 1C → keycodes {up=0, rom(0_1C)} then {up=1, rom(0_1C)}; each appears 2 cycles after its last byte.
- 12, 1C, F0 1C, F0 12 → four entries; the middle two carry mods=4'b0001, the last carries mods=0.
- E0 75, E0 F0 75 → ROM addresses 9'h175 used; up bit 0 then 1.
- E1 14 77 E1 F0 14 F0 77 → exactly one entry, code 8'h7f up=0; no ctrl change.
- SUPPRESS_REPEAT=1: 1C ×3 then F0 1C → two entries (make, break). With SUPPRESS_REPEAT=0 → four entries.
- DEPTH=4, out_ready=0, 5 make codes → 4 entries and overflow=1. Then ovf_clr → overflow=0. Drain with out_ready=1 → entries in order. reset_n low mid-E0 → out_valid=0 and state S_IDLE at once.

Source files
------------

// File: rtl/scancode_pkg.sv
// Shared definitions for the PS/2 set-2 to lispm keycode decoder:
// FSM encodings, prefix and modifier scancodes, keycode field offsets.
package scancode_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_E0     = 3'd1,
    S_F0     = 3'd2,
    S_E0F0   = 3'd3,
    S_E1     = 3'd4,
    S_LOOKUP = 3'd5,
    S_PUSH   = 3'd6
  } state_t;

  localparam logic [7:0] PFX_E0 = 8'he0;
  localparam logic [7:0] PFX_F0 = 8'hf0;
  localparam logic [7:0] PFX_E1 = 8'he1;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_META   = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Bytes following E1 that belong to the Pause sequence.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;
  localparam logic [8:0] NO_KEY     = 9'h1ff;

  localparam int UP_BIT   = 8;
  localparam int MODS_LSB = 9;

endpackage

// File: rtl/scancode_decoder_fifo.sv
// Keycode queue: power-of-two ring with extra-MSB pointers and a sticky
// overflow flag. A pop frees a slot for a push in the same cycle.
module keycode_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty, full, do_pop, do_push, drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign not_empty = !empty;

endmodule

// File: rtl/scancode_rom.sv
// Combinational map from {ext, scancode} to an 8-bit lispm key code.
// Unlisted addresses map to 8'h00.
module scancode_rom (
  input  logic [8:0] addr,
  output logic [7:0] code
);

  always_comb begin
    code = 8'h00;
    case (addr)
      9'h01c:  code = 8'h41;
      9'h032:  code = 8'h42;
      9'h021:  code = 8'h43;
      9'h023:  code = 8'h44;
      9'h024:  code = 8'h45;
      9'h016:  code = 8'h31;
      9'h012:  code = 8'h80;
      9'h059:  code = 8'h81;
      9'h014:  code = 8'h82;
      9'h114:  code = 8'h83;
      9'h011:  code = 8'h84;
      9'h111:  code = 8'h85;
      9'h058:  code = 8'h86;
      9'h175:  code = 8'h90;
      9'h172:  code = 8'h91;
      9'h16b:  code = 8'h92;
      9'h174:  code = 8'h93;
      default: code = 8'h00;
    endcase
  end

endmodule

// File: rtl/scancode_decoder.sv
// PS/2 set-2 byte stream to lispm keycode converter: prefix FSM, modifier
// tracking, optional typematic suppression and an output keycode queue.
module scancode_decoder
  import scancode_pkg::*;
#(
  parameter int         DEPTH           = 8,
  parameter int         SUPPRESS_REPEAT = 1,
  parameter logic [7:0] PAUSE_CODE      = 8'h7f
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        strobe_in,
  input  logic [7:0]  code_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] keycode,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic [3:0]  mods,
  output logic [2:0]  dbg_state
);

  // Output handshake: keycode holds the queue head while out_valid is high;
  // the entry is consumed at the edge where out_valid && out_ready.

  state_t      state, state_nxt;
  logic [7:0]  sc;
  logic        ext, up, pause;
  logic [2:0]  skip;
  logic [8:0]  last_down;
  logic [1:0]  shift_lr, ctrl_lr, meta_lr;
  logic [1:0]  shift_nxt, ctrl_nxt, meta_nxt;
  logic        caps, caps_nxt;
  logic [8:0]  rom_addr;
  logic [7:0]  rom_code;
  logic        byte_acc, discard;
  logic [3:0]  mods_nxt;
  logic [15:0] push_data;
  logic        push_en;

  assign byte_acc = strobe_in && (state != S_LOOKUP) && (state != S_PUSH);
  assign rom_addr = {ext, sc};

  scancode_rom u_rom (
    .addr (rom_addr),
    .code (rom_code)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (strobe_in) begin
        if (code_in == PFX_E0)      state_nxt = S_E0;
        else if (code_in == PFX_F0) state_nxt = S_F0;
        else if (code_in == PFX_E1) state_nxt = S_E1;
        else                        state_nxt = S_LOOKUP;
      end
      S_E0:     if (strobe_in) state_nxt = (code_in == PFX_F0) ? S_E0F0 : S_LOOKUP;
      S_F0:     if (strobe_in) state_nxt = S_LOOKUP;
      S_E0F0:   if (strobe_in) state_nxt = S_LOOKUP;
      S_E1:     if (strobe_in && skip == 3'd1) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = S_PUSH;
      S_PUSH:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign discard = (SUPPRESS_REPEAT != 0) && !pause && !up && (rom_addr == last_down);

  // Pause and suppressed repeats leave the modifier state alone.
  always_comb begin
    shift_nxt = shift_lr;
    ctrl_nxt  = ctrl_lr;
    meta_nxt  = meta_lr;
    caps_nxt  = caps;
    if (!pause && !discard) begin
      case (rom_addr)
        {1'b0, SC_LSHIFT}: shift_nxt[0] = !up;
        {1'b0, SC_RSHIFT}: shift_nxt[1] = !up;
        {1'b0, SC_CTRL}:   ctrl_nxt[0]  = !up;
        {1'b1, SC_CTRL}:   ctrl_nxt[1]  = !up;
        {1'b0, SC_META}:   meta_nxt[0]  = !up;
        {1'b1, SC_META}:   meta_nxt[1]  = !up;
        {1'b0, SC_CAPS}:   if (!up) caps_nxt = !caps;
        default: ;
      endcase
    end
  end

  assign mods_nxt = {caps_nxt, |meta_nxt, |ctrl_nxt, |shift_nxt};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      sc    <= 8'h00;
      ext   <= 1'b0;
      up    <= 1'b0;
      pause <= 1'b0;
      skip  <= 3'd0;
    end else begin
      state <= state_nxt;
      if (byte_acc) sc <= code_in;
      case (state)
        S_IDLE: if (strobe_in) begin
          ext   <= (code_in == PFX_E0);
          up    <= (code_in == PFX_F0);
          pause <= 1'b0;
          if (code_in == PFX_E1) skip <= PAUSE_SKIP;
        end
        S_E0: if (strobe_in && code_in == PFX_F0) up <= 1'b1;
        S_E1: if (strobe_in) begin
          skip <= skip - 1'b1;
          if (skip == 3'd1) pause <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_lr  <= 2'b00;
      ctrl_lr   <= 2'b00;
      meta_lr   <= 2'b00;
      caps      <= 1'b0;
      last_down <= NO_KEY;
      push_data <= 16'h0000;
      push_en   <= 1'b0;
    end else if (state == S_LOOKUP) begin
      shift_lr  <= shift_nxt;
      ctrl_lr   <= ctrl_nxt;
      meta_lr   <= meta_nxt;
      caps      <= caps_nxt;
      push_en   <= !discard;
      push_data <= {3'b000, mods_nxt, up, pause ? PAUSE_CODE : rom_code};
      if (!pause) begin
        if (!up)                        last_down <= rom_addr;
        else if (rom_addr == last_down) last_down <= NO_KEY;
      end
    end
  end

  keycode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      ((state == S_PUSH) && push_en),
    .push_data (push_data),
    .pop       (out_valid && out_ready),
    .ovf_clr   (ovf_clr),
    .head      (keycode),
    .not_empty (out_valid),
    .overflow  (overflow)
  );

  assign mods      = {caps, |meta_lr, |ctrl_lr, |shift_lr};
  assign dbg_state = state;

endmodule

// File: tb/tb_scancode_decoder.sv
// Directed bench for scancode_decoder: three instances (default, no repeat
// suppression, 4-deep queue), per-scenario tasks with inline checks.
module tb_scancode_decoder;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_E0     = 3'd1;
  localparam logic [2:0] ST_LOOKUP = 3'd5;
  localparam logic [2:0] ST_PUSH   = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  code_in;
  logic [2:0]  strobe_v, ready_v;
  logic        ovf_clr;
  logic [2:0]  ov, ovf;
  logic [15:0] kc [3];
  logic [3:0]  md [3];
  logic [2:0]  st [3];

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scancode_decoder #(.DEPTH(8), .SUPPRESS_REPEAT(1), .PAUSE_CODE(8'h7f)) dut (
    .clk(clk), .reset_n(reset_n), .strobe_in(strobe_v[0]), .code_in(code_in),
    .out_valid(ov[0]), .out_ready(ready_v[0]), .keycode(kc[0]), .overflow(ovf[0]),
    .ovf_clr(ovf_clr), .mods(md[0]), .dbg_state(st[0]));

  scancode_decoder #(.DEPTH(8), .SUPPRESS_REPEAT(0), .PAUSE_CODE(8'h7f)) dut_nr (
    .clk(clk), .reset_n(reset_n), .strobe_in(strobe_v[1]), .code_in(code_in),
    .out_valid(ov[1]), .out_ready(ready_v[1]), .keycode(kc[1]), .overflow(ovf[1]),
    .ovf_clr(ovf_clr), .mods(md[1]), .dbg_state(st[1]));

  scancode_decoder #(.DEPTH(4), .SUPPRESS_REPEAT(1), .PAUSE_CODE(8'h7f)) dut_d4 (
    .clk(clk), .reset_n(reset_n), .strobe_in(strobe_v[2]), .code_in(code_in),
    .out_valid(ov[2]), .out_ready(ready_v[2]), .keycode(kc[2]), .overflow(ovf[2]),
    .ovf_clr(ovf_clr), .mods(md[2]), .dbg_state(st[2]));

  // One-cycle strobe to the selected instances, then three idle cycles.
  task automatic send_byte(input logic [2:0] m, input logic [7:0] b);
    code_in  = b;
    strobe_v = m;
    @(posedge clk); #1;
    strobe_v = 3'b000;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Pops everything queued in instance k into got_q (bounded).
  task automatic collect(input int k);
    got_q.delete();
    for (int i = 0; i < 12; i++) begin
      if (ov[k] !== 1'b1) break;
      got_q.push_back(kc[k]);
      ready_v[k] = 1'b1;
      @(posedge clk); #1;
      ready_v[k] = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ov[0]); end
    checks++; if (kc[0] !== 16'h0000) begin errors++; $display("FAIL reset_keycode: got %h want 0000", kc[0]); end
    checks++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", ovf[0]); end
    checks++; if (md[0] !== 4'h0) begin errors++; $display("FAIL reset_mods: got %h want 0", md[0]); end
    checks++; if (st[0] !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", st[0]); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_make_break;
    // make 1C: sampled at edge k, written at edge k+2
    code_in = 8'h1c; strobe_v = 3'b001;
    @(posedge clk); #1; strobe_v = 3'b000;
    checks++; if (st[0] !== ST_LOOKUP) begin errors++; $display("FAIL mk_lookup_state: got %0d want 5", st[0]); end
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL mk_valid_k1: got %b want 0", ov[0]); end
    @(posedge clk); #1;
    checks++; if (st[0] !== ST_PUSH) begin errors++; $display("FAIL mk_push_state: got %0d want 6", st[0]); end
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL mk_valid_k2: got %b want 0", ov[0]); end
    @(posedge clk); #1;
    checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL mk_valid_k3: got %b want 1", ov[0]); end
    checks++; if (kc[0] !== 16'h0041) begin errors++; $display("FAIL mk_keycode: got %h want 0041", kc[0]); end
    // head must hold while not accepted
    @(posedge clk); #1;
    checks++; if (kc[0] !== 16'h0041 || ov[0] !== 1'b1) begin errors++; $display("FAIL mk_hold: got %h/%b want 0041/1", kc[0], ov[0]); end
    ready_v[0] = 1'b1; @(posedge clk); #1; ready_v[0] = 1'b0;
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL mk_popped: got %b want 0", ov[0]); end
    // break F0 1C
    send_byte(3'b001, 8'hf0);
    code_in = 8'h1c; strobe_v = 3'b001;
    @(posedge clk); #1; strobe_v = 3'b000;
    @(posedge clk); #1;
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL brk_valid_k2: got %b want 0", ov[0]); end
    @(posedge clk); #1;
    checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL brk_valid_k3: got %b want 1", ov[0]); end
    checks++; if (kc[0] !== 16'h0141) begin errors++; $display("FAIL brk_keycode: got %h want 0141", kc[0]); end
    collect(0);
  endtask

  task automatic test_shift;
    send_byte(3'b001, 8'h12);
    checks++; if (md[0] !== 4'b0001) begin errors++; $display("FAIL shift_live: got %b want 0001", md[0]); end
    send_byte(3'b001, 8'h1c);
    send_byte(3'b001, 8'hf0); send_byte(3'b001, 8'h1c);
    send_byte(3'b001, 8'hf0); send_byte(3'b001, 8'h12);
    checks++; if (md[0] !== 4'b0000) begin errors++; $display("FAIL shift_released: got %b want 0000", md[0]); end
    exp_q = '{16'h0280, 16'h0241, 16'h0341, 16'h0180};
    collect(0);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL shift_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL shift_entry%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_extended;
    send_byte(3'b001, 8'he0); send_byte(3'b001, 8'h75);
    send_byte(3'b001, 8'he0); send_byte(3'b001, 8'hf0); send_byte(3'b001, 8'h75);
    exp_q = '{16'h0090, 16'h0190};
    collect(0);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ext_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ext_entry%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_pause;
    logic [7:0] seq [8];
    seq = '{8'he1, 8'h14, 8'h77, 8'he1, 8'hf0, 8'h14, 8'hf0, 8'h77};
    for (int i = 0; i < 8; i++) send_byte(3'b001, seq[i]);
    checks++; if (md[0] !== 4'h0) begin errors++; $display("FAIL pause_mods: got %h want 0", md[0]); end
    checks++; if (st[0] !== ST_IDLE) begin errors++; $display("FAIL pause_state: got %0d want 0", st[0]); end
    collect(0);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL pause_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 16'h007f) begin errors++; $display("FAIL pause_entry: got %h want 007f", got_q[0]); end
    end
  endtask

  task automatic test_repeat;
    for (int i = 0; i < 3; i++) send_byte(3'b011, 8'h1c);
    send_byte(3'b011, 8'hf0); send_byte(3'b011, 8'h1c);
    exp_q = '{16'h0041, 16'h0141};
    collect(0);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rep_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rep_entry%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q = '{16'h0041, 16'h0041, 16'h0041, 16'h0141};
    collect(1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL norep_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL norep_entry%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_caps;
    send_byte(3'b001, 8'h58);
    checks++; if (md[0] !== 4'b1000) begin errors++; $display("FAIL caps_on: got %b want 1000", md[0]); end
    send_byte(3'b001, 8'hf0); send_byte(3'b001, 8'h58);
    send_byte(3'b001, 8'h58);
    checks++; if (md[0] !== 4'b0000) begin errors++; $display("FAIL caps_off: got %b want 0000", md[0]); end
    send_byte(3'b001, 8'hf0); send_byte(3'b001, 8'h58);
    exp_q = '{16'h1086, 16'h1186, 16'h0086, 16'h0186};
    collect(0);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL caps_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL caps_entry%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow;
    logic [7:0] keys [5];
    keys = '{8'h1c, 8'h32, 8'h21, 8'h23, 8'h24};
    for (int i = 0; i < 4; i++) send_byte(3'b100, keys[i]);
    checks++; if (ovf[2] !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b want 0", ovf[2]); end
    send_byte(3'b100, keys[4]);
    checks++; if (ovf[2] !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf[2]); end
    checks++; if (ov[2] !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b want 1", ov[2]); end
    ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0;
    checks++; if (ovf[2] !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf[2]); end
    exp_q = '{16'h0041, 16'h0042, 16'h0043, 16'h0044};
    collect(2);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_entry%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_seq;
    send_byte(3'b001, 8'h58);
    send_byte(3'b001, 8'he0);
    checks++; if (st[0] !== ST_E0) begin errors++; $display("FAIL mid_pre_state: got %0d want 1", st[0]); end
    checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", ov[0]); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (st[0] !== ST_IDLE) begin errors++; $display("FAIL mid_state: got %0d want 0", st[0]); end
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", ov[0]); end
    checks++; if (md[0] !== 4'h0) begin errors++; $display("FAIL mid_mods: got %h want 0", md[0]); end
    checks++; if (kc[0] !== 16'h0000) begin errors++; $display("FAIL mid_keycode: got %h want 0000", kc[0]); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ov[0] !== 1'b0 || st[0] !== ST_IDLE) begin errors++; $display("FAIL mid_after: got %b/%0d want 0/0", ov[0], st[0]); end
  endtask

  initial begin
    reset_n  = 1'b0;
    code_in  = 8'h00;
    strobe_v = 3'b000;
    ready_v  = 3'b000;
    ovf_clr  = 1'b0;
    test_reset;
    test_make_break;
    test_shift;
    test_extended;
    test_pause;
    test_repeat;
    test_caps;
    test_overflow;
    test_reset_mid_seq;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
